// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared types, PRBS7 tap defaults and prediction function
//
// Contents:
//   prbs_state_e  : checker state (ST_SEED, ST_HUNT, ST_LOCKED), 2 bits
//   PRBS7_TAP_A/B : default feedback taps for x^7+x^6+1
//   prbs_predict  : next-bit prediction from a history vector
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 7;

  // History is passed zero-extended to 32 bits so one function serves any
  // LFSR length; taps are 1-based delays (h[0] is the newest bit).
  function automatic logic prbs_predict(input logic [31:0] h,
                                        input int unsigned tap_a,
                                        input int unsigned tap_b);
    return h[tap_b - 1] ^ h[tap_a - 1];
  endfunction

endpackage

// File: rtl/prbs_history.sv
// rtl/prbs_history.sv - N-bit PRBS history shift register with prediction
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears history
//   en       : shift enable (one new bit per enabled cycle)
//   load_ext : 1 = shift in bit_in, 0 = shift in own prediction (free-run)
//   bit_in   : external bit
//   hist     : current history, hist[0] newest
//   pred     : combinational prediction of the next stream bit
module prbs_history
  import prbs_pkg::*;
#(
  parameter int unsigned N     = 7,
  parameter int unsigned TAP_A = PRBS7_TAP_A,
  parameter int unsigned TAP_B = PRBS7_TAP_B
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load_ext,
  input  logic         bit_in,
  output logic [N-1:0] hist,
  output logic         pred
);

  logic [N-1:0] h_q, h_d;

  always_comb begin
    pred = prbs_predict(32'(h_q), TAP_A, TAP_B);
    h_d  = h_q;
    if (en) begin
      h_d = {h_q[N-2:0], (load_ext ? bit_in : pred)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
    end else begin
      h_q <= h_d;
    end
  end

  assign hist = h_q;

endmodule

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - self-synchronising serial PRBS7 checker with error counter
//
// Ports:
//   CLK       : rising-edge clock
//   RESET     : synchronous active-high reset, overrides VALID
//   I         : received serial bit
//   VALID     : I is sampled only when high; all state holds when low
//   LOCKED    : high while locked to the stream
//   ERR       : one-cycle pulse per counted bit error
//   ERR_COUNT : saturating count of errors seen while locked
//   O         : current history register (debug)
//   BIT_COUNT : valid cycles spent locked, saturating (only with
//               PRBS7_CHECKER_BITCNT_EN defined)
//
// Optional build macro: PRBS7_CHECKER_BITCNT_EN adds BIT_COUNT.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int unsigned N           = 7,
  parameter int unsigned TAP_A       = PRBS7_TAP_A,
  parameter int unsigned TAP_B       = PRBS7_TAP_B,
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned UNLOCK_ERRS = 4,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I,
  input  logic             VALID,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [N-1:0]     O
`ifdef PRBS7_CHECKER_BITCNT_EN
  ,
  output logic [31:0]      BIT_COUNT
`endif
);

  localparam int FILL_W   = (N > 1) ? $clog2(N) : 1;
  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int STREAK_W = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]   FILL_LAST   = FILL_W'(N - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LOCK  = MATCH_W'(LOCK_COUNT);
  localparam logic [STREAK_W-1:0] STREAK_DROP = STREAK_W'(UNLOCK_ERRS);

  prbs_state_e         state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic         load_ext;
  logic         pred;
  logic         bit_ok;
  logic [N-1:0] hist;

  prbs_history #(
    .N     (N),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_hist (
    .clk      (CLK),
    .reset    (RESET),
    .en       (VALID),
    .load_ext (load_ext),
    .bit_in   (I),
    .hist     (hist),
    .pred     (pred)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    match_d   = match_q;
    streak_d  = streak_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    // Once locked the history free-runs on its own prediction, so a line
    // error cannot corrupt later predictions.
    load_ext  = (state_q != ST_LOCKED);
    bit_ok    = (I == pred);

    case (state_q)
      ST_SEED: begin
        if (VALID) begin
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            state_d = ST_HUNT;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end

      ST_HUNT: begin
        if (VALID) begin
          // An all-zero history trivially predicts zeros; never count it
          // toward lock so a stuck-at-0 line is rejected.
          if (hist == '0 || !bit_ok) begin
            match_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
            if (match_d == MATCH_LOCK) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
              streak_d = '0;
            end
          end
        end
      end

      ST_LOCKED: begin
        if (VALID) begin
          if (!bit_ok) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            streak_d = streak_q + STREAK_W'(1);
            if (streak_d == STREAK_DROP) begin
              state_d  = ST_SEED;
              locked_d = 1'b0;
              fill_d   = '0;
              match_d  = '0;
              streak_d = '0;
            end
          end else begin
            streak_d = '0;
          end
        end
      end

      default: begin
        state_d  = ST_SEED;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SEED;
      fill_q    <= '0;
      match_q   <= '0;
      streak_q  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      streak_q  <= streak_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign ERR_COUNT = err_cnt_q;
  assign O         = hist;

`ifdef PRBS7_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (state_q != ST_LOCKED && state_d == ST_LOCKED) begin
      bit_cnt_d = '0;
    end else if (state_q == ST_LOCKED && VALID && bit_cnt_q != '1) begin
      bit_cnt_d = bit_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign BIT_COUNT = bit_cnt_q;
`endif

endmodule

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Serial PRBS checker; the receive end of the 7-bit Fibonacci LFSR pattern generator (polynomial x^7+x^6+1).
- Samples one bit per valid cycle and self-synchronises to the incoming stream.
- Declares lock after a run of correct predictions, then counts bit errors for link and board bring-up.
- Sits after the pin or deserializer; its outputs feed status LEDs or a debug register.

Parameters:
- N, 7, LFSR length in bits.
- TAP_A, 6, first feedback tap (1-based delay). Prediction uses h[TAP_A-1].
- TAP_B, 7, second feedback tap (1-based delay). Prediction uses h[TAP_B-1].
- LOCK_COUNT, 16, consecutive matches in HUNT required to declare lock.
- UNLOCK_ERRS, 4, consecutive mismatches in LOCKED that force resync.
- ERR_W, 16, width of the error counter.

Ports:
- CLK, input, 1, rising-edge clock.
- RESET, input, 1, synchronous, active-high reset.
- I, input, 1, received serial PRBS bit.
- VALID, input, 1, I is sampled only when VALID=1. All state holds when VALID=0.
- LOCKED, output, 1, high while in LOCKED state.
- ERR, output, 1, one-cycle pulse on a counted bit error.
- ERR_COUNT, output, ERR_W, saturating count of errors seen while locked.
- O, output, N, current history register (debug).

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high. It is sampled on the CLK rising edge and overrides VALID.
- Reset values: state=SEED, history h=0, fill=0, match=0, streak=0, LOCKED=0, ERR=0, ERR_COUNT=0.
- Prediction: p = h[TAP_B-1] XOR h[TAP_A-1]. This is the combinational prediction of the next stream bit. Stream law: b(n) = b(n-6) XOR b(n-7).
- History register h:
  - Shifts left each valid cycle; h[0] takes the new bit, h[k] takes h[k-1].
  - In SEED and HUNT, the new bit is the received I (self-synchronising load).
  - In LOCKED, the new bit is p (free-running), so a single line error does not propagate into the predictor.
- SEED state:
  - Loads I for N valid cycles (fill counter 0..N-1), then moves to HUNT.
  - No comparison is made in SEED.
- HUNT state:
  - On a valid cycle, compare I to p.
  - Mismatch: match=0, stay in HUNT (h still loads I).
  - Match: match++.
  - When match reaches LOCK_COUNT and h is non-zero, move to LOCKED on that same edge; LOCKED goes high the next cycle.
  - All-zero history: h==0 never locks (a stuck-at-0 line is rejected). match is held at 0 while h==0.
- LOCKED state:
  - Mismatch on a valid cycle: ERR=1 for that one cycle (registered, 1-cycle latency after the sampling edge), ERR_COUNT++, streak++.
  - Match on a valid cycle: streak=0.
  - When streak reaches UNLOCK_ERRS: move to SEED, LOCKED=0, fill=0, match=0. ERR_COUNT is retained.
  - The mismatch that triggers the unlock is itself counted.
- ERR_COUNT saturates at 2^ERR_W-1; it does not wrap. It clears only on RESET.
- VALID=0: no shift, no compare. ERR=0 on the following cycle. All counters hold.
- RESET asserted mid-operation: all state returns to reset values on the next edge, regardless of VALID.

Optional Feature:
- Macro: PRBS7_CHECKER_BITCNT_EN.
- When defined:
  - Adds output BIT_COUNT, 32 bits: count of valid cycles spent in LOCKED, saturating at 2^32-1.
  - Cleared on RESET and on entry to LOCKED.
  - With ERR_COUNT, software can compute BER.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Package prbs_pkg holds:
  - state enum {SEED, HUNT, LOCKED} (2 bits);
  - default tap constants for PRBS7 (6, 7);
  - a pure prediction function over the history vector.
- One sub-module, prbs_history: N-bit shift register with a load-select input (I vs p) plus the prediction output.
  - The generator side can reuse it.

Test Plan:
- Lock from clean stream: model generator seeded 7'b0000001, VALID=1 continuously. Require LOCKED=1 exactly N+LOCK_COUNT+1 = 24 cycles after reset release; ERR_COUNT stays 0 for 1000 bits.
- Single error: while locked, invert 1 bit. Require ERR to pulse once, ERR_COUNT=1, LOCKED stays 1, and the next 200 bits produce no further ERR.
- Loss of lock: while locked, invert 4 consecutive bits. Require ERR_COUNT +4 and LOCKED=0 on the cycle after the 4th error. Require relock 24 valid cycles later with ERR_COUNT unchanged.
- Stuck-at-0 line: hold I=0 for 100 cycles. Require LOCKED=0 throughout and ERR_COUNT=0. Then apply a clean stream and require lock.
- VALID gaps: clean stream with VALID toggling every other cycle. Require lock after 23 valid samples with no ERR during idle cycles.
- Saturation and reset: ERR_W=4, inject 20 isolated errors. Require ERR_COUNT=15. Assert RESET for 1 cycle mid-stream; require all outputs at reset values on the next cycle.
